// File: rtl/color_sequence_player.sv
// color_sequence_player: plays back the first round_len entries of a latched
// colour sequence. Each entry is shown for ON_CYCLES clocks, followed by a
// GAP_CYCLES blank. A start/busy/done handshake is provided, and abort cancels
// playback. All outputs come straight from flops.
module color_sequence_player #(
    parameter int COLOR_W    = 2,
    parameter int MAX_LEN    = 16,
    parameter int ON_CYCLES  = 4,
    parameter int GAP_CYCLES = 2,
    parameter int LEN_W      = $clog2(MAX_LEN + 1)
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [MAX_LEN*COLOR_W-1:0] seq_in,
    input  logic [LEN_W-1:0]           round_len,
    input  logic                       start,
    input  logic                       abort,
    output logic                       busy,
    output logic                       color_valid,
    output logic [COLOR_W-1:0]         color_out,
    output logic [LEN_W-1:0]           step_idx,
    output logic                       done
);

    localparam int TIMER_MAX = (ON_CYCLES > GAP_CYCLES) ? ON_CYCLES : GAP_CYCLES;
    localparam int TIMER_W   = $clog2(TIMER_MAX + 1);
    localparam int SEQ_W     = MAX_LEN * COLOR_W;

    localparam logic [LEN_W-1:0]   MAX_LEN_L = LEN_W'(MAX_LEN);
    localparam logic [TIMER_W-1:0] ON_LAST   = TIMER_W'(ON_CYCLES - 1);
    localparam logic [TIMER_W-1:0] GAP_LAST  = TIMER_W'(GAP_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ON   = 2'd1,
        GAP  = 2'd2,
        DONE = 2'd3
    } stateType;

    stateType             state, nextState;
    logic [TIMER_W-1:0]   timer, nextTimer;
    logic [LEN_W-1:0]     lenReg, nextLen;
    logic [SEQ_W-1:0]     seqReg, nextSeq;
    logic [LEN_W-1:0]     nextStep;
    logic                 gapExit;
    logic                 lastStep;
    logic                 nextBusy, nextValid, nextDone;
    logic [COLOR_W-1:0]   nextColor;

    // True while the entry being played is the final one of this round.
    assign lastStep = (step_idx == lenReg - LEN_W'(1));

    // Next-state, next-timer and next-output computation.
    always_comb begin
        // NOTE: every variable gets a default first so no path leaves it
        // unassigned; otherwise synthesis would infer a latch.
        nextState = state;
        nextTimer = timer;
        nextLen   = lenReg;
        nextSeq   = seqReg;
        nextStep  = step_idx;
        gapExit   = 1'b0;

        case (state)
            IDLE: begin
                if (start) begin
                    nextSeq   = seq_in;
                    nextLen   = (round_len > MAX_LEN_L) ? MAX_LEN_L : round_len;
                    nextStep  = '0;
                    nextTimer = '0;
                    nextState = (nextLen == '0) ? DONE : ON;
                end
            end
            ON: begin
                if (abort) begin
                    nextState = IDLE;
                    nextStep  = '0;
                    nextTimer = '0;
                end else if (timer == ON_LAST) begin
                    if (GAP_CYCLES == 0) begin
                        gapExit = 1'b1;
                    end else begin
                        nextState = GAP;
                        nextTimer = '0;
                    end
                end else begin
                    nextTimer = timer + TIMER_W'(1);
                end
            end
            GAP: begin
                if (abort) begin
                    nextState = IDLE;
                    nextStep  = '0;
                    nextTimer = '0;
                end else if (timer == GAP_LAST) begin
                    gapExit = 1'b1;
                end else begin
                    nextTimer = timer + TIMER_W'(1);
                end
            end
            DONE: begin
                nextState = IDLE;
                nextStep  = '0;
                nextTimer = '0;
            end
            default: begin
                nextState = IDLE;
            end
        endcase

        // End of one entry's slot: either finish the round or advance.
        if (gapExit) begin
            nextTimer = '0;
            if (lastStep) begin
                nextState = DONE;
            end else begin
                nextState = ON;
                nextStep  = step_idx + LEN_W'(1);
            end
        end

        // Outputs are derived from the upcoming state so they can be registered.
        nextBusy  = (nextState != IDLE);
        nextValid = (nextState == ON);
        nextDone  = (nextState == DONE);
        nextColor = nextValid ? nextSeq[int'(nextStep) * COLOR_W +: COLOR_W] : '0;
    end

    // State, timer, latched round data and registered outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            // NOTE: the latched sequence is a plain register bank, not a RAM,
            // so clearing it on reset costs nothing and keeps it deterministic.
            state       <= IDLE;
            timer       <= '0;
            lenReg      <= '0;
            seqReg      <= '0;
            busy        <= 1'b0;
            color_valid <= 1'b0;
            color_out   <= '0;
            step_idx    <= '0;
            done        <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every flop samples the values
            // from before this edge, regardless of statement order.
            state       <= nextState;
            timer       <= nextTimer;
            lenReg      <= nextLen;
            seqReg      <= nextSeq;
            busy        <= nextBusy;
            color_valid <= nextValid;
            color_out   <= nextColor;
            step_idx    <= nextStep;
            done        <= nextDone;
        end
    end

endmodule

// File: tb/tb_color_sequence_player.sv
// Testbench for color_sequence_player. It drives randomized rounds into two
// instances: the default timing (ON=4, GAP=2) and a no-gap variant (ON=3,
// GAP=0). It compares every output cycle by cycle against a cycle-indexed
// arithmetic model of the playback schedule.
module tb_color_sequence_player;

    localparam int COLOR_W = 2;
    localparam int MAX_LEN = 16;
    localparam int LEN_W   = 5;
    localparam int SEQ_W   = MAX_LEN * COLOR_W;
    localparam int OBS_W   = 3 + COLOR_W + LEN_W;

    logic               clk;
    logic               reset;
    logic [SEQ_W-1:0]   seqIn;
    logic [LEN_W-1:0]   roundLen;
    logic               startA, abortA, startB, abortB;

    logic               busyA, validA, doneA, busyB, validB, doneB;
    logic [COLOR_W-1:0] colorA, colorB;
    logic [LEN_W-1:0]   stepA, stepB;

    logic [OBS_W-1:0]   obsA, obsB;

    int nCompared;
    int nMismatched;

    color_sequence_player #(
        .COLOR_W(COLOR_W), .MAX_LEN(MAX_LEN), .ON_CYCLES(4), .GAP_CYCLES(2)
    ) dutA (
        .clk(clk), .reset(reset), .seq_in(seqIn), .round_len(roundLen),
        .start(startA), .abort(abortA), .busy(busyA), .color_valid(validA),
        .color_out(colorA), .step_idx(stepA), .done(doneA)
    );

    color_sequence_player #(
        .COLOR_W(COLOR_W), .MAX_LEN(MAX_LEN), .ON_CYCLES(3), .GAP_CYCLES(0)
    ) dutB (
        .clk(clk), .reset(reset), .seq_in(seqIn), .round_len(roundLen),
        .start(startB), .abort(abortB), .busy(busyB), .color_valid(validB),
        .color_out(colorB), .step_idx(stepB), .done(doneB)
    );

    assign obsA = {busyA, validA, colorA, stepA, doneA};
    assign obsB = {busyB, validB, colorB, stepB, doneB};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Expected {busy,valid,color,step,done} in cycle k (k=1 is the cycle right
    // after the start edge). The schedule is one slot of on+gap cycles per entry,
    // then a single done cycle, then idle. An abort inside the play window
    // zeroes everything after the cycle in which abort was held.
    function automatic logic [OBS_W-1:0] model(input bit useB, input logic [SEQ_W-1:0] seqv,
                                              input int len, input int k, input int abortAt);
        int onLen   = useB ? 3 : 4;
        int gapLen  = useB ? 0 : 2;
        int period  = onLen + gapLen;
        int playEnd = len * period;
        int idx, phase;
        logic valid;
        logic [COLOR_W-1:0] color;
        logic [SEQ_W-1:0] s;
        if (abortAt >= 1 && abortAt <= playEnd && k > abortAt) return '0;
        if (k <= playEnd) begin
            idx   = (k - 1) / period;
            phase = (k - 1) % period;
            valid = (phase < onLen);
            s     = seqv >> (idx * COLOR_W);
            color = valid ? s[COLOR_W-1:0] : '0;
            return {1'b1, valid, color, LEN_W'(idx), 1'b0};
        end
        if (k == playEnd + 1) return {1'b1, 1'b0, {COLOR_W{1'b0}}, LEN_W'((len > 0) ? len - 1 : 0), 1'b1};
        return '0;
    endfunction

    task automatic setStart(input bit useB, input logic v);
        if (useB) startB = v; else startA = v;
    endtask

    task automatic setAbort(input bit useB, input logic v);
        if (useB) abortB = v; else abortA = v;
    endtask

    // Plays one round on the selected instance and checks every cycle.
    // abortAt: -1 none, 0 together with start, k>=1 held during cycle k.
    task automatic runRound(input string name, input bit useB, input logic [SEQ_W-1:0] seqv,
                            input int rl, input int abortAt, input bit perturb);
        int len     = (rl > MAX_LEN) ? MAX_LEN : rl;
        int period  = useB ? 3 : 6;
        int playEnd = len * period;
        int total   = (abortAt >= 1 && abortAt <= playEnd) ? abortAt + 3 : playEnd + 3;
        logic [OBS_W-1:0] expv, obs;
        @(negedge clk);
        seqIn    = seqv;
        roundLen = LEN_W'(rl);
        setStart(useB, 1'b1);
        setAbort(useB, abortAt == 0);
        @(negedge clk);
        setStart(useB, 1'b0);
        setAbort(useB, 1'b0);
        for (int k = 1; k <= total; k++) begin
            expv = model(useB, seqv, len, k, abortAt);
            obs  = useB ? obsB : obsA;
            nCompared++;
            if (obs !== expv) begin
                nMismatched++;
                $display("FAIL %s cycle %0d: {busy,valid,color,step,done} got %b expected %b",
                         name, k, obs, expv);
            end
            setStart(useB, (perturb && k < playEnd) ? 1'($urandom_range(1)) : 1'b0);
            setAbort(useB, k == abortAt);
            if (perturb) begin
                seqIn    = $urandom;
                roundLen = LEN_W'($urandom);
            end
            @(negedge clk);
        end
        setStart(useB, 1'b0);
        setAbort(useB, 1'b0);
    endtask

    task automatic test_reset;
        reset = 1'b1;
        #12;
        nCompared++;
        if (obsA !== '0) begin nMismatched++; $display("FAIL reset_a: got %b expected 0", obsA); end
        nCompared++;
        if (obsB !== '0) begin nMismatched++; $display("FAIL reset_b: got %b expected 0", obsB); end
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic test_basic;
        logic [SEQ_W-1:0] s = $urandom;
        s[1:0] = 2'd2; s[3:2] = 2'd1; s[5:4] = 2'd3;
        runRound("basic_213", 1'b0, s, 3, -1, 1'b0);
    endtask

    task automatic test_zero_len;
        runRound("zero_len", 1'b0, SEQ_W'($urandom), 0, -1, 1'b0);
    endtask

    task automatic test_overflow_len;
        runRound("overflow_len", 1'b0, SEQ_W'($urandom), MAX_LEN + 5, -1, 1'b0);
    endtask

    task automatic test_abort;
        logic [SEQ_W-1:0] s = $urandom;
        runRound("abort_2nd_on", 1'b0, s, 4, 8, 1'b0);
        runRound("replay_after_abort", 1'b0, s, 4, -1, 1'b0);
        runRound("abort_in_gap", 1'b0, SEQ_W'($urandom), 3, 11, 1'b0);
        runRound("abort_with_start", 1'b0, SEQ_W'($urandom), 2, 0, 1'b0);
        runRound("abort_in_done", 1'b0, SEQ_W'($urandom), 2, 13, 1'b0);
    endtask

    task automatic test_perturb;
        runRound("perturb_a", 1'b0, SEQ_W'($urandom), 5, -1, 1'b1);
        runRound("perturb_b", 1'b1, SEQ_W'($urandom), 6, -1, 1'b1);
    endtask

    task automatic test_random;
        for (int i = 0; i < 6; i++) begin
            runRound("random_a", 1'b0, SEQ_W'($urandom), int'($urandom_range(MAX_LEN + 4)), -1, 1'b0);
        end
    endtask

    task automatic test_no_gap;
        runRound("no_gap_full", 1'b1, SEQ_W'($urandom), MAX_LEN, -1, 1'b0);
        runRound("no_gap_short", 1'b1, SEQ_W'($urandom), 2, -1, 1'b0);
        runRound("no_gap_abort", 1'b1, SEQ_W'($urandom), 4, 5, 1'b0);
    endtask

    task automatic test_async_reset;
        @(negedge clk);
        seqIn    = $urandom;
        roundLen = LEN_W'(3);
        startA   = 1'b1;
        @(negedge clk);
        startA = 1'b0;
        repeat (4) @(negedge clk);
        nCompared++;
        if ({busyA, validA} !== 2'b10) begin
            nMismatched++;
            $display("FAIL async_reset_pre: {busy,valid} got %b expected 10", {busyA, validA});
        end
        #2 reset = 1'b1;
        #1;
        nCompared++;
        if (obsA !== '0) begin nMismatched++; $display("FAIL async_reset_mid: got %b expected 0", obsA); end
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        nCompared++;
        if (obsA !== '0) begin nMismatched++; $display("FAIL async_reset_after: got %b expected 0", obsA); end
    endtask

    initial begin
        nCompared   = 0;
        nMismatched = 0;
        seqIn    = '0;
        roundLen = '0;
        startA   = 1'b0;
        abortA   = 1'b0;
        startB   = 1'b0;
        abortB   = 1'b0;
        test_reset();
        test_basic();
        test_zero_len();
        test_overflow_len();
        test_abort();
        test_perturb();
        test_random();
        test_no_gap();
        test_async_reset();
        test_basic();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
        $finish;
    end

endmodule
